// File: rtl/mic_dma_pkg.sv
// Shared types and default parameters for the microphone-array DMA engine.
package mic_dma_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 24;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_FRAME = 3'd2,
    WRITE      = 3'd3,
    NEXT       = 3'd4,
    FIN        = 3'd5
  } state_t;

endpackage

// File: rtl/mic_dma_addr_gen.sv
// Incremental address generator: a per-sample row pointer plus a per-channel
// pointer that walks the channel regions by adding the stride, no multiplier.
module mic_dma_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              row_init_i,
  input  logic              row_step_i,
  input  logic              frame_load_i,
  input  logic              ch_step_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    row_d  = row_q;
    addr_d = addr_q;
    if (row_init_i)      row_d = base_i;
    else if (row_step_i) row_d = row_q + ADDR_W'(4);
    // row_q is base + 4*idx; each channel step adds one region length
    if (frame_load_i)    addr_d = row_q;
    else if (ch_step_i)  addr_d = addr_q + stride_i;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mic_array_dma.sv
// Microphone-array DMA: each sample_valid frame is written channel by channel
// into per-channel regions over an Avalon-MM write master.
//
// state      | meaning
// IDLE       | waiting for start, configuration latched on launch
// ARM        | empty-run check, row pointer initialised
// WAIT_FRAME | waiting for the next sample_valid frame
// WRITE      | issuing one write per channel back to back
// NEXT       | advance sample index, decide end of run
// FIN        | run complete, held until start drops
module mic_array_dma
  import mic_dma_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [ADDR_W-1:0]   AM_ADDR,
  output logic                AM_WRITE,
  output logic [DATA_W-1:0]   AM_WRITEDATA,
  output logic [DATA_W/8-1:0] AM_BYTEENABLE,
  output logic [2:0]          AM_BURSTCOUNT,
  input  logic                AM_WAITREQUEST,
  input  logic [DATA_W-1:0]   mic_data,
  output logic [CH_W-1:0]     select,
  input  logic                sample_valid,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   start_address,
  input  logic [CNT_W-1:0]    number_samples,
  output logic                busy,
  output logic                FINISHED,
  output logic                overrun
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              overrun_q, overrun_d;
  logic              abort_q, abort_d;

  logic wr_done, last_ch, last_idx, abort_pend;
  logic row_init, row_step, frame_load, ch_step;

  assign wr_done    = (state_q == WRITE) && !AM_WAITREQUEST;
  assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
  assign last_idx   = ((idx_q + CNT_W'(1)) == total_q);
  assign abort_pend = abort_q || abort;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    stride_d   = stride_q;
    total_d    = total_q;
    idx_d      = idx_q;
    ch_d       = ch_q;
    overrun_d  = overrun_q;
    abort_d    = 1'b0;
    row_init   = 1'b0;
    row_step   = 1'b0;
    frame_load = 1'b0;
    ch_step    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d    = start_address;
          total_d   = number_samples;
          stride_d  = ADDR_W'(number_samples) << 2;
          idx_d     = '0;
          ch_d      = '0;
          overrun_d = 1'b0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (abort)                state_d = IDLE;
        else if (total_q == '0)   state_d = FIN;
        else begin
          row_init = 1'b1;
          state_d  = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (abort) state_d = IDLE;
        else if (sample_valid) begin
          ch_d       = '0;
          frame_load = 1'b1;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (sample_valid) overrun_d = 1'b1;
        // an abort seen during a stall is remembered until the write lands
        abort_d = abort_pend && !wr_done;
        if (wr_done) begin
          if (abort_pend) state_d = IDLE;
          else if (!last_ch) begin
            ch_d    = ch_q + CH_W'(1);
            ch_step = 1'b1;
          end else begin
            ch_d    = '0;
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (sample_valid) overrun_d = 1'b1;
        if (abort)         state_d = IDLE;
        else if (last_idx) state_d = FIN;
        else begin
          idx_d    = idx_q + CNT_W'(1);
          row_step = 1'b1;
          state_d  = WAIT_FRAME;
        end
      end
      FIN: begin
        if (abort || !start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      total_q   <= '0;
      idx_q     <= '0;
      ch_q      <= '0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
      abort_q   <= abort_d;
    end
  end

  mic_dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .CLK          (CLK),
    .RESET        (RESET),
    .base_i       (base_q),
    .stride_i     (stride_q),
    .row_init_i   (row_init),
    .row_step_i   (row_step),
    .frame_load_i (frame_load),
    .ch_step_i    (ch_step),
    .addr_o       (AM_ADDR)
  );

  assign AM_WRITE      = (state_q == WRITE);
  assign AM_WRITEDATA  = mic_data;
  assign AM_BYTEENABLE = '1;
  assign AM_BURSTCOUNT = 3'd1;
  assign select        = (state_q == WRITE) ? ch_q : '0;
  assign busy          = (state_q != IDLE) && (state_q != FIN);
  assign FINISHED      = (state_q == FIN);
  assign overrun       = overrun_q;

endmodule

// File: doc/mic_array_dma.md
MIC_ARRAY_DMA -- requirements
Module: mic_array_dma

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_CH, 4, number of microphone channels, 2..16.
- DATA_W, 32, sample width.
- ADDR_W, 32, byte-address width.
- CNT_W, 24, sample-count width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- AM_ADDR  out  ADDR_W  Avalon-MM master byte address.
- AM_WRITE  out  1  write request.
- AM_WRITEDATA  out  DATA_W  equals mic_data combinationally.
- AM_BYTEENABLE  out  DATA_W/8  all ones.
- AM_BURSTCOUNT  out  3  constant 1.
- AM_WAITREQUEST  in  1  slave stall.
- mic_data  in  DATA_W  sample of the channel named by select.
- select  out  $clog2(NUM_CH)  channel mux select.
- sample_valid  in  1  one-cycle strobe: a new frame of all channels is ready.
- start  in  1  level; run request.
- abort  in  1  level; cancel the run.
- start_address  in  ADDR_W  base of the channel-0 region.
- number_samples  in  CNT_W  samples per channel.
- busy  out  1  high in any state except IDLE and FIN.
- FINISHED  out  1  run complete.
- overrun  out  1  sticky flag: a frame was dropped.

Function
REQ-003 States SHALL be IDLE, ARM, WAIT_FRAME, WRITE, NEXT, FIN.
REQ-004 IDLE: when start=1 and abort=0, latch start_address to base, number_samples to total and 4*number_samples (mod 2^ADDR_W) to stride; clear idx, ch and overrun; go to ARM.
REQ-005 ARM: if total=0, go to FIN; otherwise go to WAIT_FRAME.
REQ-006 WAIT_FRAME: on sample_valid, set ch=0 and go to WRITE.
REQ-007 WRITE: AM_WRITE=1 and AM_ADDR=base+ch*stride+4*idx, both registered and stable while AM_WAITREQUEST=1.
REQ-008 A write SHALL complete on the first cycle with AM_WRITE=1 and AM_WAITREQUEST=0.
REQ-009 When a write completes and ch<NUM_CH-1, ch SHALL increment and the FSM SHALL stay in WRITE with no AM_WRITE gap cycle.
REQ-010 When a write completes and ch=NUM_CH-1, AM_WRITE SHALL drop and the FSM SHALL go to NEXT.
REQ-011 NEXT: idx increments; if idx+1=total, go to FIN, else go to WAIT_FRAME.
REQ-012 select SHALL equal ch in WRITE and 0 elsewhere.
REQ-013 sample_valid seen in WRITE or NEXT SHALL set overrun; the frame is dropped and no extra writes are issued.
REQ-014 FIN: FINISHED=1, AM_WRITE=0; hold while start=1; go to IDLE when start=0, FINISHED dropping on entry to IDLE.
REQ-015 abort=1 outside WRITE SHALL go to IDLE next cycle.
REQ-016 abort=1 in WRITE SHALL let the in-flight write complete, then go to IDLE with FINISHED=0.
REQ-017 start changes during a run SHALL be ignored; latched values apply until IDLE.
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_W; idx and ch SHALL never exceed total-1 and NUM_CH-1.

Reset
REQ-019 RESET SHALL force state=IDLE, AM_WRITE=0, AM_ADDR=0, select=0, busy=0, FINISHED=0, overrun=0, idx=0, ch=0, base=0, stride=0, total=0.
REQ-020 RESET SHALL take priority over all inputs, including mid-write with AM_WAITREQUEST=1.

Structure
REQ-021 Package mic_dma_pkg SHALL hold the state enum and default parameter constants.
REQ-022 Sub-module mic_dma_addr_gen SHALL compute AM_ADDR from base, stride, ch and idx as a registered incremental adder, with no multiplier in the path.

Verification
REQ-023 The bench SHALL cover these scenarios:
- NUM_CH=4, start_address=0x1000, number_samples=2, no stall, two frames -> 8 writes to 0x1000, 0x1008, 0x1010, 0x1018, 0x1004, 0x100C, 0x1014, 0x101C; select 0..3 per frame; FINISHED=1.
- AM_WAITREQUEST high 3 cycles on channel 2 -> AM_ADDR and AM_WRITE held stable; exactly one write accepted per channel.
- number_samples=0 -> no AM_WRITE; FINISHED=1 within 2 cycles of start.
- sample_valid pulsed during WRITE -> overrun=1, write count unchanged, run completes normally.
- abort during a stalled write -> that write completes, then IDLE, FINISHED=0, busy=0.
- RESET mid-run with AM_WAITREQUEST=1 -> all REQ-019 values next cycle; a new start runs cleanly.
